// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_pkg
// Purpose  : Shared state codes and default widths for the FIFO bank
//            controller and its threshold register sub-block.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    localparam int STATE_W          = 3;
    localparam int DEF_UMBRAL_WIDTH = 4;

    localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/umbral_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : umbral_cfg_regs
// Purpose  : Almost-empty / almost-full threshold registers. They track the
//            requested values while load_en_i is high and hold otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module umbral_cfg_regs
    import fifo_ctrl_pkg::*;
#(
    parameter int UMBRAL_WIDTH = DEF_UMBRAL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    load_en_i,
    input  logic [UMBRAL_WIDTH-1:0] bajo_i,
    input  logic [UMBRAL_WIDTH-1:0] alto_i,
    output logic [UMBRAL_WIDTH-1:0] bajo_o,
    output logic [UMBRAL_WIDTH-1:0] alto_o
);

    logic [UMBRAL_WIDTH-1:0] bajo_q;
    logic [UMBRAL_WIDTH-1:0] alto_q;

    // Load both thresholds on every enabled edge; the last value before the
    // enable drops is the one that stays frozen.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bajo_q <= '0;
            alto_q <= '0;
        end else if (load_en_i) begin
            bajo_q <= bajo_i;
            alto_q <= alto_i;
        end
    end

    assign bajo_o = bajo_q;
    assign alto_o = alto_q;

endmodule : umbral_cfg_regs
`default_nettype wire

// File: rtl/fifo_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_fsm
// Purpose  : Power-up / run-time sequencer for the transmit-layer FIFO bank.
//            RESET -> INIT -> IDLE <-> ACTIVE, with a sticky ERROR state,
//            frozen thresholds and a latched record of FIFO error sources.
// Options  : FIFO_CTRL_ERRCNT_EN adds a saturating 8-bit count of ERROR
//            entries on port err_count (cleared only by reset_L).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_fsm
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS    = 4,
    parameter int UMBRAL_WIDTH = DEF_UMBRAL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_bajo_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_alto_in,
    input  logic [NUM_FIFOS-1:0]    fifo_empty,
    input  logic [NUM_FIFOS-1:0]    fifo_error,
    output logic                    fifo_init,
    output logic [UMBRAL_WIDTH-1:0] umbral_bajo_out,
    output logic [UMBRAL_WIDTH-1:0] umbral_alto_out,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out,
    output logic [NUM_FIFOS-1:0]    error_src,
    output logic [STATE_W-1:0]      state
`ifdef FIFO_CTRL_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    state_e               state_q;
    state_e               state_d;
    logic [NUM_FIFOS-1:0] err_src_q;
    logic [NUM_FIFOS-1:0] err_src_d;

    // State and error-source registers; both clear asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_RESET;
            err_src_q <= '0;
        end else begin
            state_q   <= state_d;
            err_src_q <= err_src_d;
        end
    end

    // Next state and error-source update; fifo_error has priority over init
    // so a fault coinciding with a reconfiguration request is never lost.
    always_comb begin
        state_d   = S_RESET;
        err_src_d = err_src_q;
        case (state_q)
            S_RESET: begin
                state_d   = S_INIT;
                err_src_d = '0;
            end
            S_INIT: begin
                state_d   = init ? S_INIT : S_IDLE;
                err_src_d = '0;
            end
            S_IDLE: begin
                if (|fifo_error) begin
                    state_d   = S_ERROR;
                    err_src_d = fifo_error;
                end else if (init) begin
                    state_d   = S_INIT;
                    err_src_d = '0;
                end else if (~&fifo_empty) begin
                    state_d = S_ACTIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (|fifo_error) begin
                    state_d   = S_ERROR;
                    err_src_d = fifo_error;
                end else if (init) begin
                    state_d   = S_INIT;
                    err_src_d = '0;
                end else if (&fifo_empty) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_ERROR: begin
                // Only a reconfiguration (or reset) leaves ERROR; a clearing
                // fifo_error must not hide the fault.
                if (init) begin
                    state_d   = S_INIT;
                    err_src_d = '0;
                end else begin
                    state_d   = S_ERROR;
                    err_src_d = err_src_q | fifo_error;
                end
            end
            default: begin
                state_d   = S_RESET;
                err_src_d = '0;
            end
        endcase
    end

    // Thresholds track the config inputs only while in INIT.
    umbral_cfg_regs #(
        .UMBRAL_WIDTH (UMBRAL_WIDTH)
    ) u_umbral_cfg_regs (
        .clk       (clk),
        .reset_L   (reset_L),
        .load_en_i (state_q == S_INIT),
        .bajo_i    (umbral_bajo_in),
        .alto_i    (umbral_alto_in),
        .bajo_o    (umbral_bajo_out),
        .alto_o    (umbral_alto_out)
    );

    // Outputs decode the state register only, so nothing from the inputs
    // reaches them combinationally. FIFOs stay initialised in ERROR so
    // their contents survive for debug.
    assign fifo_init  = (state_q == S_IDLE) || (state_q == S_ACTIVE) ||
                        (state_q == S_ERROR);
    assign idle_out   = (state_q == S_IDLE);
    assign active_out = (state_q == S_ACTIVE);
    assign error_out  = (state_q == S_ERROR);
    assign error_src  = err_src_q;
    assign state      = state_q;

`ifdef FIFO_CTRL_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count entries into ERROR, saturating; INIT deliberately leaves it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt_q <= 8'd0;
        end else if ((state_d == S_ERROR) && (state_q != S_ERROR) &&
                     (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule : fifo_ctrl_fsm
`default_nettype wire

// File: tb/tb_fifo_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl_fsm
// Purpose  : Directed, table-driven self-checking bench for fifo_ctrl_fsm.
// Options  : FIFO_CTRL_ERRCNT_EN enables the err_count sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_fsm;

    localparam int NF = 4;
    localparam int UW = 4;
    localparam int NV = 26;

    typedef struct {
        logic          init;
        logic [UW-1:0] bajo;
        logic [UW-1:0] alto;
        logic [NF-1:0] empty;
        logic [NF-1:0] err;
        logic [2:0]    exp_st;
        logic [UW-1:0] exp_bajo;
        logic [UW-1:0] exp_alto;
        logic [NF-1:0] exp_src;
    } vec_t;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [UW-1:0] umbral_bajo_in;
    logic [UW-1:0] umbral_alto_in;
    logic [NF-1:0] fifo_empty;
    logic [NF-1:0] fifo_error;
    logic          fifo_init;
    logic [UW-1:0] umbral_bajo_out;
    logic [UW-1:0] umbral_alto_out;
    logic          idle_out;
    logic          active_out;
    logic          error_out;
    logic [NF-1:0] error_src;
    logic [2:0]    state;
`ifdef FIFO_CTRL_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vec [NV];

    fifo_ctrl_fsm #(
        .NUM_FIFOS    (NF),
        .UMBRAL_WIDTH (UW)
    ) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .init            (init),
        .umbral_bajo_in  (umbral_bajo_in),
        .umbral_alto_in  (umbral_alto_in),
        .fifo_empty      (fifo_empty),
        .fifo_error      (fifo_error),
        .fifo_init       (fifo_init),
        .umbral_bajo_out (umbral_bajo_out),
        .umbral_alto_out (umbral_alto_out),
        .idle_out        (idle_out),
        .active_out      (active_out),
        .error_out       (error_out),
        .error_src       (error_src),
        .state           (state)
`ifdef FIFO_CTRL_ERRCNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Full output comparison against an expected state/threshold/src set.
    task automatic chk_all(input int idx, input logic [2:0] st,
                           input logic [UW-1:0] eb, input logic [UW-1:0] ea,
                           input logic [NF-1:0] es);
        logic fi;
        fi = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        chk("state",     idx, 32'(state),           32'(st));
        chk("fifo_init", idx, 32'(fifo_init),       32'(fi));
        chk("idle",      idx, 32'(idle_out),        32'(st == 3'd2));
        chk("active",    idx, 32'(active_out),      32'(st == 3'd3));
        chk("error",     idx, 32'(error_out),       32'(st == 3'd4));
        chk("bajo",      idx, 32'(umbral_bajo_out), 32'(eb));
        chk("alto",      idx, 32'(umbral_alto_out), 32'(ea));
        chk("src",       idx, 32'(error_src),       32'(es));
    endtask

    task automatic tick(input logic i_init, input logic [NF-1:0] i_empty,
                        input logic [NF-1:0] i_err);
        init       = i_init;
        fifo_empty = i_empty;
        fifo_error = i_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // init bajo alto empty err -> state bajo alto src
        vec[0]  = '{1'b1, 4'd2, 4'd3, 4'hF, 4'h0, 3'd1, 4'd0, 4'd0, 4'h0};
        vec[1]  = '{1'b1, 4'd2, 4'd3, 4'hF, 4'h0, 3'd1, 4'd2, 4'd3, 4'h0};
        vec[2]  = '{1'b1, 4'd1, 4'd3, 4'hF, 4'h0, 3'd1, 4'd1, 4'd3, 4'h0};
        vec[3]  = '{1'b0, 4'd1, 4'd3, 4'hF, 4'h0, 3'd2, 4'd1, 4'd3, 4'h0};
        vec[4]  = '{1'b0, 4'd7, 4'd7, 4'hF, 4'h0, 3'd2, 4'd1, 4'd3, 4'h0};
        vec[5]  = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h0, 3'd3, 4'd1, 4'd3, 4'h0};
        vec[6]  = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h0, 3'd3, 4'd1, 4'd3, 4'h0};
        vec[7]  = '{1'b0, 4'd7, 4'd7, 4'hF, 4'h0, 3'd2, 4'd1, 4'd3, 4'h0};
        vec[8]  = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h0, 3'd3, 4'd1, 4'd3, 4'h0};
        vec[9]  = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h4, 3'd4, 4'd1, 4'd3, 4'h4};
        vec[10] = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h1, 3'd4, 4'd1, 4'd3, 4'h5};
        vec[11] = '{1'b0, 4'd7, 4'd7, 4'hD, 4'h0, 3'd4, 4'd1, 4'd3, 4'h5};
        vec[12] = '{1'b0, 4'd7, 4'd7, 4'hF, 4'h0, 3'd4, 4'd1, 4'd3, 4'h5};
        vec[13] = '{1'b1, 4'd7, 4'd7, 4'hF, 4'h0, 3'd1, 4'd1, 4'd3, 4'h0};
        vec[14] = '{1'b1, 4'd7, 4'd7, 4'hF, 4'h0, 3'd1, 4'd7, 4'd7, 4'h0};
        vec[15] = '{1'b0, 4'd5, 4'd9, 4'hF, 4'h0, 3'd2, 4'd5, 4'd9, 4'h0};
        vec[16] = '{1'b1, 4'd5, 4'd9, 4'hF, 4'h2, 3'd4, 4'd5, 4'd9, 4'h2};
        vec[17] = '{1'b0, 4'd5, 4'd9, 4'hF, 4'h0, 3'd4, 4'd5, 4'd9, 4'h2};
        vec[18] = '{1'b1, 4'd5, 4'd9, 4'hF, 4'h0, 3'd1, 4'd5, 4'd9, 4'h0};
        vec[19] = '{1'b0, 4'd5, 4'd9, 4'hF, 4'h0, 3'd2, 4'd5, 4'd9, 4'h0};
        vec[20] = '{1'b1, 4'd5, 4'd9, 4'h0, 4'h0, 3'd1, 4'd5, 4'd9, 4'h0};
        vec[21] = '{1'b0, 4'd5, 4'd9, 4'h0, 4'h0, 3'd2, 4'd5, 4'd9, 4'h0};
        vec[22] = '{1'b0, 4'd5, 4'd9, 4'h0, 4'h0, 3'd3, 4'd5, 4'd9, 4'h0};
        vec[23] = '{1'b1, 4'd5, 4'd9, 4'h0, 4'h0, 3'd1, 4'd5, 4'd9, 4'h0};
        vec[24] = '{1'b0, 4'd5, 4'd9, 4'h0, 4'h0, 3'd2, 4'd5, 4'd9, 4'h0};
        vec[25] = '{1'b0, 4'd5, 4'd9, 4'h0, 4'h0, 3'd3, 4'd5, 4'd9, 4'h0};

        reset_L        = 1'b0;
        init           = 1'b1;
        umbral_bajo_in = 4'd2;
        umbral_alto_in = 4'd3;
        fifo_empty     = 4'hF;
        fifo_error     = 4'h0;

        // Reset held for three edges: everything zero.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_all(100 + c, 3'd0, 4'd0, 4'd0, 4'h0);
        end
        reset_L = 1'b1;
        #1;
        chk_all(103, 3'd0, 4'd0, 4'd0, 4'h0);

        // Main table.
        for (int i = 0; i < NV; i++) begin
            init           = vec[i].init;
            umbral_bajo_in = vec[i].bajo;
            umbral_alto_in = vec[i].alto;
            fifo_empty     = vec[i].empty;
            fifo_error     = vec[i].err;
            @(posedge clk);
            #1;
            chk_all(i, vec[i].exp_st, vec[i].exp_bajo, vec[i].exp_alto,
                    vec[i].exp_src);
        end

        // Asynchronous reset in the middle of a cycle while ACTIVE.
        #2;
        reset_L = 1'b0;
        #1;
        chk_all(200, 3'd0, 4'd0, 4'd0, 4'h0);
        init = 1'b1;
        @(posedge clk);
        #1;
        chk_all(201, 3'd0, 4'd0, 4'd0, 4'h0);
        reset_L = 1'b1;
        tick(1'b1, 4'hF, 4'h0);
        chk_all(202, 3'd1, 4'd0, 4'd0, 4'h0);

`ifdef FIFO_CTRL_ERRCNT_EN
        chk("err_count_rst", 300, 32'(err_count), 32'd0);
        tick(1'b0, 4'hF, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 4'hF, 4'h1);
            chk("err_state", 310 + k, 32'(state), 32'd4);
            tick(1'b0, 4'hF, 4'h0);
            tick(1'b1, 4'hF, 4'h0);
            tick(1'b0, 4'hF, 4'h0);
        end
        chk("err_count3", 301, 32'(err_count), 32'd3);
        tick(1'b1, 4'hF, 4'h0);
        chk("init_state", 302, 32'(state), 32'd1);
        chk("err_count_init", 303, 32'(err_count), 32'd3);
        #2;
        reset_L = 1'b0;
        #1;
        chk("err_count_clr", 304, 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_ctrl_fsm
`default_nettype wire

// File: doc/fifo_ctrl_fsm.md
Name: fifo_ctrl_fsm

Overview:
Power-up and run-time controller for the transmit-layer FIFO bank (D0/D1/VC-type FIFOs with umbral thresholds and a shared init input). Sequences the bank through RESET/INIT/IDLE/ACTIVE/ERROR and drives the FIFOs' common init. Captures and freezes the almost-empty/almost-full thresholds, and latches FIFO error sources. Sits between the configuration interface and every FIFO instance in the bank.

Parameters:
NUM_FIFOS, 4, number of FIFOs supervised (width of empty/error vectors)
UMBRAL_WIDTH, 4, width of each threshold field

Ports:
clk  in  1  single clock, all state on rising edge
reset_L  in  1  asynchronous, active-low reset
init  in  1  configuration request from the config interface; high = hold in INIT
umbral_bajo_in  in  UMBRAL_WIDTH  requested almost-empty threshold
umbral_alto_in  in  UMBRAL_WIDTH  requested almost-full threshold
fifo_empty  in  NUM_FIFOS  empty flag per FIFO
fifo_error  in  NUM_FIFOS  error (write-when-full) flag per FIFO
fifo_init  out  1  drives init of every FIFO; 0 = FIFOs held cleared
umbral_bajo_out  out  UMBRAL_WIDTH  frozen almost-empty threshold to FIFOs
umbral_alto_out  out  UMBRAL_WIDTH  frozen almost-full threshold to FIFOs
idle_out  out  1  high in IDLE
active_out  out  1  high in ACTIVE
error_out  out  1  high in ERROR
error_src  out  NUM_FIFOS  sticky record of which FIFO(s) raised error
state  out  3  current state encoding

Behaviour:
- State encoding (3-bit binary): RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5-7 go to RESET on the next edge.
- reset_L=0, asynchronous, including mid-operation: state=RESET; all outputs 0, including fifo_init, both thresholds and error_src.
- All outputs are registered: they change on the same edge as state, with no combinational path from inputs.
- RESET: on the first edge with reset_L=1 -> INIT unconditionally.
- INIT: fifo_init=0.
  - umbral_*_out load umbral_*_in on every edge spent in INIT, so the last value seen before leaving wins.
  - error_src cleared.
  - init=0 -> IDLE, and thresholds freeze.
  - init=1 -> stay.
- IDLE: fifo_init=1.
  - Priority: |fifo_error -> ERROR; else init=1 -> INIT; else ~&fifo_empty -> ACTIVE; else stay.
- ACTIVE: fifo_init=1.
  - Priority: |fifo_error -> ERROR; else init=1 -> INIT; else &fifo_empty -> IDLE; else stay.
- Error capture: on entry to ERROR, error_src <= fifo_error. While in ERROR, error_src <= error_src | fifo_error (sticky OR).
- ERROR: fifo_init stays 1 so FIFO contents remain available for debug.
  - Exit only via init=1 -> INIT, or via reset_L.
  - fifo_error deasserting does not exit ERROR.
- Thresholds: changes on umbral_*_in outside INIT are ignored. No ordering check between bajo and alto; a legal pair is the config interface's responsibility.
- init and fifo_error asserted in the same cycle from IDLE/ACTIVE: ERROR wins.

Optional Feature:
FIFO_CTRL_ERRCNT_EN
- Defined: adds output err_count [7:0]. It increments by 1 on every transition into ERROR and saturates at 255. It is cleared only by reset_L; INIT does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_ctrl_pkg holds:
  - state code localparams ST_RESET..ST_ERROR
  - STATE_W=3
  - default UMBRAL_WIDTH
- Natural sub-module: umbral_cfg_regs. It holds the two threshold registers plus load-enable (state==INIT) and async clear. It is instantiated once.
- FSM and error latch stay in fifo_ctrl_fsm.

Test Plan:
1. reset_L=0 for 3 cycles, then release with init=1 -> RESET (0) then INIT (1) on the next edge, fifo_init=0, all other outputs 0.
2. In INIT, drive bajo=2, alto=3, then bajo=1 on the final INIT cycle, then init=0 -> IDLE, umbral_bajo_out=1, umbral_alto_out=3. Changing inputs to 7/7 afterwards leaves the outputs at 1/3.
3. IDLE with fifo_empty=4'b1111, then 4'b1101 -> ACTIVE next edge, active_out=1. Return to 4'b1111 -> IDLE next edge.
4. ACTIVE, pulse fifo_error=4'b0100 for 1 cycle, then fifo_error=4'b0001 -> ERROR with error_src=4'b0101, held after errors clear. Then init=1 -> INIT, error_src=0.
5. Same cycle init=1 and fifo_error=4'b0010 from IDLE -> ERROR, not INIT.
6. Assert reset_L=0 asynchronously mid-cycle while in ACTIVE -> outputs zero immediately, before the next edge. With FIFO_CTRL_ERRCNT_EN, drive 3 ERROR entries -> err_count=3, kept across INIT, cleared by reset_L.
